// File: rtl/mips_mem_pkg.sv
// Shared types and encodings for the data-cache miss controller.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  localparam int unsigned MEM_LATENCY_DEFAULT = 4;
  // Wide enough to hold MEM_LATENCY itself (up to 15), one past terminal count.
  localparam int unsigned CNT_W = 4;

  localparam logic CIT_CPU    = 1'b0;
  localparam logic CIT_MEM    = 1'b1;
  localparam logic MAT_CPU    = 1'b0;
  localparam logic MAT_VICTIM = 1'b1;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipeline/cache-array side signals of the data-cache controller.
interface dcache_ctrl_if;
  logic req_read;
  logic req_write;
  logic cache_hit;
  logic cache_dirty;
  logic cache_valid;
  logic halted;
  logic pc_enable;
  logic we_cache;
  logic set_valid;
  logic set_dirty;
  logic cache_input_type;
  logic memory_address_type;
  logic mem_we;

  modport master (
    output req_read, req_write, cache_hit, cache_dirty, cache_valid, halted,
    input  pc_enable, we_cache, set_valid, set_dirty, cache_input_type,
           memory_address_type, mem_we
  );

  modport slave (
    input  req_read, req_write, cache_hit, cache_dirty, cache_valid, halted,
    output pc_enable, we_cache, set_valid, set_dirty, cache_input_type,
           memory_address_type, mem_we
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Up-counter timing one main-memory line transfer; done marks its last cycle.
module mem_wait_counter
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(MEM_LATENCY - 1));

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking data-cache controller: hit service, dirty-victim writeback, line refill.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | evaluate request; hits complete, misses stall and start transfer
// S_WRITEBACK | victim line written to memory for MEM_LATENCY cycles
// S_REFILL    | line read from memory; written into cache on the last cycle
module dcache_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  dcache_ctrl_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  state_t           state_q, state_d;
  logic             cnt_clear, cnt_en, cnt_done;
  logic [CNT_W-1:0] wait_cnt;
  logic             retry, request, is_store;
  logic             hit_inc, miss_inc;
  logic             pc_enable, we_cache, set_valid, set_dirty, cit, mat, mem_we;

  mem_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .done   (cnt_done),
    .count  (wait_cnt)
  );

  // The counter keeps running through the last refill cycle, so it reads
  // MEM_LATENCY only in the IDLE cycle that directly follows a refill.
  assign retry    = (wait_cnt == CNT_W'(MEM_LATENCY));
  assign request  = bus.req_read | bus.req_write;
  assign is_store = bus.req_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_enable = 1'b1;
    we_cache  = 1'b0;
    set_valid = 1'b0;
    set_dirty = 1'b0;
    cit       = CIT_CPU;
    mat       = MAT_CPU;
    mem_we    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_clear = 1'b1;
        if (request && !bus.halted) begin
          if (bus.cache_hit) begin
            hit_inc = !retry;
            if (is_store) begin
              we_cache  = 1'b1;
              set_valid = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            pc_enable = 1'b0;
            miss_inc  = !retry;
            state_d   = (bus.cache_valid && bus.cache_dirty) ? S_WRITEBACK : S_REFILL;
          end
        end
      end
      S_WRITEBACK: begin
        pc_enable = 1'b0;
        mat       = MAT_VICTIM;
        mem_we    = 1'b1;
        cnt_en    = 1'b1;
        if (cnt_done) begin
          cnt_clear = 1'b1;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        pc_enable = 1'b0;
        cnt_en    = 1'b1;
        if (cnt_done) begin
          we_cache  = 1'b1;
          set_valid = 1'b1;
          cit       = CIT_MEM;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      pc_enable = 1'b0;
      we_cache  = 1'b0;
      set_valid = 1'b0;
      set_dirty = 1'b0;
      cit       = CIT_CPU;
      mat       = MAT_CPU;
      mem_we    = 1'b0;
      hit_inc   = 1'b0;
      miss_inc  = 1'b0;
    end
  end

  assign bus.pc_enable           = pc_enable;
  assign bus.we_cache            = we_cache;
  assign bus.set_valid           = set_valid;
  assign bus.set_dirty           = set_dirty;
  assign bus.cache_input_type    = cit;
  assign bus.memory_address_type = mat;
  assign bus.mem_we              = mem_we;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a transaction-level miss model.
module tb_dcache_ctrl;
  import mips_mem_pkg::*;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count, miss_count;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.MEM_LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // {pc_enable, we_cache, set_valid, set_dirty, cache_input_type, memory_address_type, mem_we}
  wire [6:0] obs = {bus.pc_enable, bus.we_cache, bus.set_valid, bus.set_dirty,
                    bus.cache_input_type, bus.memory_address_type, bus.mem_we};

  localparam logic [6:0] V_ZERO      = 7'b000_0000;
  localparam logic [6:0] V_IDLE      = 7'b100_0000;
  localparam logic [6:0] V_WB        = {6'b00_0000 | {5'b0, MAT_VICTIM}, 1'b1};
  localparam logic [6:0] V_FILL_LAST = {1'b0, 1'b1, 1'b1, 1'b0, CIT_MEM, MAT_CPU, 1'b0};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          low_cnt;
  logic [31:0] exp_hits, exp_miss;

  function automatic logic [6:0] v_hit(input logic store);
    return {1'b1, store, store, store, CIT_CPU, MAT_CPU, 1'b0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic hit,
                         input logic valid, input logic dirty, input logic halt);
    bus.req_read    = rd;
    bus.req_write   = wr;
    bus.cache_hit   = hit;
    bus.cache_valid = valid;
    bus.cache_dirty = dirty;
    bus.halted      = halt;
  endtask

  // Inputs are already set; sample outputs mid-cycle, then move past the edge.
  task automatic cycle_check(input string tag, input logic [6:0] e);
    @(negedge clk);
    if (obs[6] == 1'b0) low_cnt++;
    check_eq(tag, {25'b0, obs}, {25'b0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_hits"}, hit_count, exp_hits);
    check_eq({tag, "_misses"}, miss_count, exp_miss);
  endtask

  // Garbage on the request lines while a transfer is in flight.
  task automatic scramble(input logic halt);
    set_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), halt);
  endtask

  task automatic run_request(input logic rd, input logic wr, input logic hit,
                             input logic valid, input logic dirty, input logic halt_mid);
    logic store;
    int   exp_stall;
    store = wr;
    set_req(rd, wr, hit, valid, dirty, 1'b0);
    if (!rd && !wr) begin
      cycle_check("idle", V_IDLE);
      return;
    end
    if (hit) begin
      exp_hits++;
      cycle_check("hit", v_hit(store));
    end else begin
      exp_miss++;
      exp_stall = (valid && dirty) ? 2 * L : L;
      cycle_check("miss_detect", V_ZERO);
      low_cnt = 0;
      if (valid && dirty) begin
        for (int i = 0; i < int'(L); i++) begin
          scramble(halt_mid);
          cycle_check("writeback", V_WB);
        end
      end
      for (int i = 0; i < int'(L); i++) begin
        scramble(halt_mid);
        if (i == int'(L) - 1) cycle_check("refill_last", V_FILL_LAST);
        else                  cycle_check("refill", V_ZERO);
      end
      check_eq("stall_cycles", low_cnt, exp_stall);
      set_req(rd, wr, 1'b1, 1'b1, 1'b0, halt_mid);
      if (halt_mid) cycle_check("retry_halted", V_IDLE);
      else          cycle_check("retry", v_hit(store));
    end
    check_counters("req");
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    low_cnt  = 0;
    exp_hits = 0;
    exp_miss = 0;
    rst = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle_check("reset_outputs", V_ZERO);
    cycle_check("reset_outputs2", V_ZERO);
    rst = 1'b0;
    check_counters("reset");

    // Directed: load hit, store hit, clean load miss, dirty store miss.
    run_request(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_request(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_request(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_request(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Dirty bit without valid is not a writeback.
    run_request(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Halt raised mid-transfer, then halted request ignored.
    run_request(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    set_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle_check("halted_req", V_IDLE);
    check_counters("halted");
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during second writeback cycle aborts the transfer.
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_miss++;
    cycle_check("rst_detect", V_ZERO);
    cycle_check("rst_wb1", V_WB);
    rst = 1'b1;
    cycle_check("rst_wb2_gated", V_ZERO);
    rst = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle_check("rst_back_idle", V_IDLE);
    check_counters("after_rst");
    run_request(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Miss counter wrap.
    force dut.miss_count = 32'hFFFF_FFFF;
    #1;
    release dut.miss_count;
    exp_miss = 32'hFFFF_FFFF;
    check_eq("miss_preset", miss_count, exp_miss);
    run_request(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("miss_wrapped", miss_count, 32'd0);

    for (int n = 0; n < 150; n++) begin
      int   kind;
      logic rd, wr;
      kind = int'($urandom_range(0, 9));
      rd   = 1'($urandom);
      wr   = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      if (kind == 0) begin
        run_request(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (kind == 1) begin
        set_req(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        cycle_check("rand_halted", V_IDLE);
        check_counters("rand_halted");
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        run_request(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 4: main-memory cycles per line transfer; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_read  in  1  MEM-stage load request this cycle.
REQ-005 req_write  in  1  MEM-stage store request this cycle.
REQ-006 cache_hit, cache_dirty, cache_valid  in  1 each  tag-compare results for the indexed line, valid same cycle.
REQ-007 halted  in  1  processor halted.
REQ-008 pc_enable  out  1  1 = pipeline advances; 0 = stall.
REQ-009 we_cache, set_valid, set_dirty  out  1 each  cache line write and status-bit write data.
REQ-010 cache_input_type  out  1  0 = store data from CPU, 1 = refill data from memory.
REQ-011 memory_address_type  out  1  0 = CPU address, 1 = victim tag address.
REQ-012 mem_we  out  1  main-memory write enable (writeback).
REQ-013 hit_count, miss_count  out  32 each  performance counters.

Function
REQ-014 States SHALL be IDLE, WRITEBACK, REFILL; state register and a wait counter are the only control state.
REQ-015 IDLE, no request or halted=1: pc_enable=1, all other control outputs 0.
REQ-016 IDLE, request and cache_hit=1: pc_enable=1; for a store, same cycle we_cache=1, cache_input_type=0, set_valid=1, set_dirty=1; hit_count +1.
REQ-017 IDLE, request and cache_hit=0: pc_enable=0 same cycle (combinational); miss_count +1; next state WRITEBACK if cache_valid&cache_dirty, else REFILL.
REQ-018 WRITEBACK: pc_enable=0, memory_address_type=1, mem_we=1 every cycle for exactly MEM_LATENCY cycles, then REFILL.
REQ-019 REFILL: pc_enable=0, memory_address_type=0, mem_we=0 for MEM_LATENCY cycles; on the last cycle only, we_cache=1, cache_input_type=1, set_valid=1, set_dirty=0; then IDLE.
REQ-020 Wait counter SHALL clear on state entry and increment each cycle; transfer ends when counter = MEM_LATENCY-1.
REQ-021 After REFILL, IDLE re-evaluates the held request; it SHALL hit and complete (a store then sets dirty); stall cycles: clean miss = MEM_LATENCY, dirty miss = 2*MEM_LATENCY.
REQ-022 req_read and req_write both 1: treated as store.
REQ-023 Hit on the retry cycle SHALL NOT increment hit_count (only first evaluation of a request counts); a counter increments at most once per request.
REQ-024 halted rising during WRITEBACK/REFILL: transfer completes, then IDLE ignores requests.
REQ-025 Counters wrap 0xFFFFFFFF -> 0 without side effects.
REQ-026 Request inputs changing mid-miss SHALL be ignored until return to IDLE.

Reset
REQ-027 rst=1 at an edge: state IDLE, wait counter 0, hit_count=miss_count=0.
REQ-028 While rst=1: pc_enable=0, all other control outputs 0, regardless of state.
REQ-029 rst mid-WRITEBACK/REFILL aborts the transfer; no cache write occurs in the reset cycle.

Structure
REQ-030 Package mips_mem_pkg SHALL hold the state enum, MEM_LATENCY default, and encodings CIT_CPU=0, CIT_MEM=1, MAT_CPU=0, MAT_VICTIM=1.
REQ-031 One sub-module mem_wait_counter (clear, enable, done at MEM_LATENCY-1) SHALL implement the wait counter; remainder in dcache_ctrl.

Verification
REQ-032 Load hit, MEM_LATENCY=4: pc_enable stays 1, we_cache=0, hit_count 0->1.
REQ-033 Store hit: one cycle we_cache=1, cache_input_type=0, set_dirty=1, pc_enable=1.
REQ-034 Clean load miss: pc_enable=0 for 4 cycles, we_cache=1 + cache_input_type=1 only in 4th, then retry hit; miss_count=1, hit_count=0.
REQ-035 Dirty store miss: mem_we=1 with memory_address_type=1 for 4 cycles, 4 refill cycles, retry store sets dirty; 8 stall cycles total.
REQ-036 rst in 2nd WRITEBACK cycle: next cycle IDLE, mem_we=0, counters 0; miss_count preset 0xFFFFFFFF then miss -> 0.
